rr_mux_sel_arbiter: RTL and testbench

Round-robin arbiter that sits directly upstream of the 8:1 byte multiplexer (mux8t1).
- Watches 8 channel request lines and drives the mux select.
- Captures the selected byte from the mux output into a registered output with a valid/ready handshake.
- Returns a one-cycle grant pulse to the winning channel so that channel can retire its byte.

---
 rtl/rr_mux_sel_arbiter_pkg.sv | 22 ++
 rtl/rr_mux_sel_arbiter_if.sv | 40 ++++
 rtl/rr_mux_sel_arbiter_pick8.sv | 24 ++
 rtl/rr_mux_sel_arbiter.sv | 120 ++++++++++++
 tb/tb_rr_mux_sel_arbiter.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/rr_mux_sel_arbiter_pkg.sv
// Shared definitions for the round-robin mux-select arbiter:
// FSM state encoding, channel/select widths, default byte width
// and a one-hot helper.
package rr_arb_pkg;

  localparam int NCH    = 8;   // channel count (fixed)
  localparam int SELW   = 3;   // mux select width
  localparam int DW_DEF = 8;   // default channel byte width
  localparam int CNTW   = 16;  // optional handshake counter width

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    HOLD    = 2'd2
  } state_t;

  // One-hot decode of a channel index.
  function automatic logic [NCH-1:0] onehot_sel(input logic [SELW-1:0] s);
    return NCH'(1) << s;
  endfunction

endpackage

// File: rtl/rr_mux_sel_arbiter_if.sv
// Bus bundle between the arbiter, the 8:1 byte mux / requesters and the
// downstream consumer. The master modport is the arbiter side.
// grant_cnt exists only when ARB_GRANT_CNT_EN is defined.
interface rr_mux_sel_arbiter_if #(
  parameter int DW = rr_arb_pkg::DW_DEF
);
  import rr_arb_pkg::*;

  logic [NCH-1:0]  req;
  logic [DW-1:0]   mux_data;
  logic [SELW-1:0] sel;
  logic [NCH-1:0]  grant;
  logic [DW-1:0]   out_data;
  logic            out_valid;
  logic            out_ready;
`ifdef ARB_GRANT_CNT_EN
  logic [CNTW-1:0] grant_cnt;

  modport master (
    input  req, mux_data, out_ready,
    output sel, grant, out_data, out_valid, grant_cnt
  );

  modport slave (
    output req, mux_data, out_ready,
    input  sel, grant, out_data, out_valid, grant_cnt
  );
`else
  modport master (
    input  req, mux_data, out_ready,
    output sel, grant, out_data, out_valid
  );

  modport slave (
    output req, mux_data, out_ready,
    input  sel, grant, out_data, out_valid
  );
`endif

endinterface

// File: rtl/rr_mux_sel_arbiter_pick8.sv
// Round-robin winner search over 8 request lines: returns the first set
// request bit scanning last+1, last+2, ... modulo 8, plus an any-request flag.
module rr_pick8
  import rr_arb_pkg::*;
(
  input  logic [NCH-1:0]  req,
  input  logic [SELW-1:0] last,
  output logic [SELW-1:0] winner,
  output logic            any
);

  // Scan from farthest to nearest so the nearest set bit after last wins.
  always_comb begin
    // NOTE: every output gets a default before the loop so no latch is inferred.
    winner = last;
    any    = |req;
    for (int i = NCH; i >= 1; i--) begin
      if (req[SELW'(int'(last) + i)]) begin
        winner = SELW'(int'(last) + i);
      end
    end
  end

endmodule

// File: rtl/rr_mux_sel_arbiter.sv
// Round-robin arbiter driving the select of an 8:1 byte mux. It registers
// the winning channel on sel, captures the mux output one cycle later into
// a valid/ready output register and pulses grant to the winning channel.
// Optional: define ARB_GRANT_CNT_EN to add a saturating 16-bit count of
// completed output handshakes on grant_cnt.
module rr_mux_sel_arbiter #(
  parameter int DW  = rr_arb_pkg::DW_DEF,
  parameter int NCH = rr_arb_pkg::NCH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  rr_mux_sel_arbiter_if.master bus
);
  import rr_arb_pkg::*;

  if (NCH != 8) begin : g_nch_check
    $error("rr_mux_sel_arbiter supports exactly 8 channels");
  end

  state_t          state_q, state_d;
  logic [SELW-1:0] sel_q;
  logic [SELW-1:0] last_q;
  logic [SELW-1:0] winner;
  logic            any_req;
  logic [NCH-1:0]  grant_q;
  logic [DW-1:0]   out_data_q;
  logic            out_valid_q;

  // Control strobes decoded from the current state.
  logic load_sel;
  logic do_capture;
  logic clr_valid;

  rr_pick8 u_pick (
    .req    (bus.req),
    .last   (last_q),
    .winner (winner),
    .any    (any_req)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; CAPTURE always lasts exactly one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = CAPTURE;
      CAPTURE: state_d = HOLD;
      HOLD:    if (bus.out_ready) state_d = any_req ? CAPTURE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode: when to load sel, capture the mux byte, or release out_valid.
  always_comb begin
    load_sel   = 1'b0;
    do_capture = 1'b0;
    clr_valid  = 1'b0;
    case (state_q)
      IDLE:    load_sel = any_req;
      CAPTURE: do_capture = 1'b1;
      HOLD: begin
        if (bus.out_ready) begin
          clr_valid = 1'b1;
          load_sel  = any_req;
        end
      end
      default: clr_valid = 1'b1;
    endcase
  end

  // Datapath: sel only moves in IDLE or on a HOLD handshake, so the mux
  // output stays coherent through CAPTURE and HOLD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q       <= '0;
      last_q      <= SELW'(NCH - 1);
      grant_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      grant_q <= do_capture ? onehot_sel(sel_q) : '0;
      if (load_sel) sel_q <= winner;
      if (do_capture) begin
        out_data_q  <= bus.mux_data;
        out_valid_q <= 1'b1;
        last_q      <= sel_q;
      end else if (clr_valid) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.sel       = sel_q;
  assign bus.grant     = grant_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;

`ifdef ARB_GRANT_CNT_EN
  logic [CNTW-1:0] grant_cnt_q;

  // Saturating count of completed output handshakes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt_q <= '0;
    end else if (out_valid_q && bus.out_ready && (grant_cnt_q != {CNTW{1'b1}})) begin
      grant_cnt_q <= grant_cnt_q + 1'b1;
    end
  end

  assign bus.grant_cnt = grant_cnt_q;
`endif

endmodule

// File: tb/tb_rr_mux_sel_arbiter.sv
// Self-checking bench for rr_mux_sel_arbiter: table of single transfers
// with hand-computed winners, then backpressure, reset-during-HOLD and
// sustained all-request sequences. Counter checks run when
// ARB_GRANT_CNT_EN is defined.
module tb_rr_mux_sel_arbiter;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  rr_mux_sel_arbiter_if #(.DW(8)) bus ();

  rr_mux_sel_arbiter #(.DW(8), .NCH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Byte mux model: channel bytes selected by the DUT's sel.
  logic [7:0] chan [8];
  always_comb bus.mux_data = chan[bus.sel];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Waits (at negedges) for out_valid; n = cycles taken, -1 on timeout.
  task automatic wait_valid(output int n);
    n = -1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) begin
        n = c;
        return;
      end
    end
  endtask

  // One transfer from IDLE: request, check capture, then handshake back to IDLE.
  task automatic run_one(input string tag, input logic [7:0] r,
                         input logic [2:0] exp_sel, input logic [7:0] exp_data);
    int n;
    logic [7:0] exp_grant;
    exp_grant = 8'(1) << exp_sel;
    bus.req       = r;
    bus.out_ready = 1'b0;
    wait_valid(n);
    check({tag, " latency"}, n, 2);
    check({tag, " sel"}, bus.sel, exp_sel);
    check({tag, " data"}, bus.out_data, exp_data);
    check({tag, " grant"}, bus.grant, exp_grant);
    bus.out_ready = 1'b1;
    bus.req       = 8'h00;
    @(negedge clk);
    check({tag, " valid cleared"}, bus.out_valid, 1'b0);
    check({tag, " grant cleared"}, bus.grant, 8'h00);
    bus.out_ready = 1'b0;
  endtask

  typedef struct {
    logic [7:0] req;
    logic [2:0] exp_sel;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs [12];

  initial begin
    int n;
    int got;
    int last_c;
    int exp_ch;

    // Winners traced by hand from last=7 after reset.
    vecs[0]  = '{8'h04, 3'd2, 8'hA5};  // first search starts at 0
    vecs[1]  = '{8'h20, 3'd5, 8'h15};  // last=5 afterwards
    vecs[2]  = '{8'h21, 3'd0, 8'h10};  // skip wraps to 0
    vecs[3]  = '{8'h21, 3'd5, 8'h15};  // then 5
    vecs[4]  = '{8'h01, 3'd0, 8'h10};  // single channel
    vecs[5]  = '{8'h01, 3'd0, 8'h10};  // single channel wins again
    vecs[6]  = '{8'h80, 3'd7, 8'h17};
    vecs[7]  = '{8'h81, 3'd0, 8'h10};  // 7 -> 0 wrap
    vecs[8]  = '{8'h81, 3'd7, 8'h17};
    vecs[9]  = '{8'h18, 3'd3, 8'h13};
    vecs[10] = '{8'h18, 3'd4, 8'h14};
    vecs[11] = '{8'h18, 3'd3, 8'h13};

    for (int i = 0; i < 8; i++) chan[i] = 8'h10 + 8'(i);
    chan[2] = 8'hA5;
    bus.req       = 8'h00;
    bus.out_ready = 1'b0;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst sel", bus.sel, 3'd0);
    check("rst grant", bus.grant, 8'h00);
    check("rst out_data", bus.out_data, 8'h00);
    check("rst out_valid", bus.out_valid, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle valid", bus.out_valid, 1'b0);
    check("idle sel hold", bus.sel, 3'd0);

    // Table of single transfers.
    for (int i = 0; i < 12; i++) begin
      run_one($sformatf("vec%0d", i), vecs[i].req, vecs[i].exp_sel, vecs[i].exp_data);
    end

    // Backpressure: five stalled HOLD cycles, then exactly one handshake.
    bus.req = 8'h04;
    wait_valid(n);
    check("bp latency", n, 2);
    check("bp sel", bus.sel, 3'd2);
    check("bp data", bus.out_data, 8'hA5);
    check("bp grant", bus.grant, 8'h04);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("bp%0d valid", k), bus.out_valid, 1'b1);
      check($sformatf("bp%0d data", k), bus.out_data, 8'hA5);
      check($sformatf("bp%0d sel", k), bus.sel, 3'd2);
      check($sformatf("bp%0d grant", k), bus.grant, 8'h00);
    end
    bus.out_ready = 1'b1;
    bus.req       = 8'h00;
    @(negedge clk);
    check("bp release valid", bus.out_valid, 1'b0);
    check("bp release grant", bus.grant, 8'h00);
    bus.out_ready = 1'b0;
    @(negedge clk);
    check("bp no second valid", bus.out_valid, 1'b0);
    check("bp no second grant", bus.grant, 8'h00);
    check("bp sel held", bus.sel, 3'd2);

    // Reset asserted while HOLD has a valid byte.
    bus.req = 8'h01;
    wait_valid(n);
    check("rh sel", bus.sel, 3'd0);
    check("rh data", bus.out_data, 8'h10);
    #2 rst_n = 1'b0;
    #1;
    check("rh async valid", bus.out_valid, 1'b0);
    check("rh async grant", bus.grant, 8'h00);
    check("rh async sel", bus.sel, 3'd0);
    bus.req = 8'h80;
    @(negedge clk);
    check("rh valid in reset", bus.out_valid, 1'b0);
    check("rh grant in reset", bus.grant, 8'h00);
    rst_n = 1'b1;
    run_one("post-rst", 8'h80, 3'd7, 8'h17);

    // Sustained all-request traffic with out_ready high.
    chan[2]       = 8'h12;
    bus.req       = 8'hFF;
    bus.out_ready = 1'b1;
    got    = 0;
    last_c = 0;
    for (int c = 1; c <= 40 && got < 9; c++) begin
      @(negedge clk);
      if (bus.grant !== 8'h00) begin
        exp_ch = got % 8;
        check($sformatf("rr%0d grant", got), bus.grant, 8'(1) << exp_ch);
        check($sformatf("rr%0d data", got), bus.out_data, 8'h10 + 8'(exp_ch));
        check($sformatf("rr%0d valid", got), bus.out_valid, 1'b1);
        if (got > 0) check($sformatf("rr%0d spacing", got), c - last_c, 2);
        last_c = c;
        got++;
        if (got == 9) bus.req = 8'h00;
      end
    end
    check("rr grant count", got, 9);
    @(negedge clk);
    check("rr drained valid", bus.out_valid, 1'b0);
    bus.out_ready = 1'b0;

`ifdef ARB_GRANT_CNT_EN
    // One handshake after the reset plus nine sustained ones.
    check("cnt after 10", bus.grant_cnt, 16'd10);
    force dut.grant_cnt_q = 16'hFFFF;
    #1;
    release dut.grant_cnt_q;
    run_one("cnt sat xfer", 8'h01, 3'd0, 8'h10);
    check("cnt saturated", bus.grant_cnt, 16'hFFFF);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

endmodule
